// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the calculator display scheduler.
// Holds the mode/state encoding, the display word width and blank word,
// and a helper that derives the scan divider ratio from the clock rates.
package disp_pkg;

   localparam int DISP_W = 24;

   typedef logic [DISP_W-1:0] disp_word_t;

   localparam disp_word_t DISP_BLANK = 24'h000000;

   localparam logic [1:0] MODE_ENTRY  = 2'd0;
   localparam logic [1:0] MODE_RESULT = 2'd1;
   localparam logic [1:0] MODE_ERROR  = 2'd2;

   // State encoding doubles as the mode output value.
   typedef enum logic [1:0] {
      ST_ENTRY  = MODE_ENTRY,
      ST_RESULT = MODE_RESULT,
      ST_ERROR  = MODE_ERROR
   } state_t;

   // Number of system clocks per half scan period.
   function automatic int scan_div(input int clk_freq, input int scan_freq);
      return clk_freq / (2 * scan_freq);
   endfunction

endpackage

// File: rtl/scan_clk_div.sv
// scan_clk_div: free-running divider producing the 50 % duty scan clock and
// a one-cycle ms_tick that coincides with each rising transition of clk_1khz.
// The counter runs 0..DIV-1; clk_1khz toggles at every wrap.
module scan_clk_div #(
   parameter int DIV = 25000
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk_1khz,
   output logic ms_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_1khz;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

   // Half-period counter and scan clock toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_clk_1khz <= 1'b0;
      end else if (w_wrap) begin
         r_cnt      <= '0;
         r_clk_1khz <= ~r_clk_1khz;
      end else begin
         r_cnt      <= r_cnt + 1'b1;
      end
   end

   assign clk_1khz = r_clk_1khz;
   // Tick on the wrap that takes the scan clock from 0 to 1.
   assign ms_tick  = w_wrap & ~r_clk_1khz;

endmodule

// File: rtl/disp_ctrl.sv
// disp_ctrl: display scheduler for the six-digit seven-segment driver.
// Arbitrates keypad entry, ALU result and error words onto a registered
// 24-bit display word, times the result hold, and generates the scan clock.
// Optional error blinking is enabled by defining DISP_ERR_BLINK_EN.
module disp_ctrl
   import disp_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int SCAN_FREQ = 1000,
   parameter int HOLD_MS   = 2000,
   parameter int BLINK_MS  = 250
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DISP_W-1:0] entry_data,
   input  logic              res_vld,
   input  logic [DISP_W-1:0] res_data,
   input  logic              err_vld,
   input  logic [DISP_W-1:0] err_data,
   input  logic              clr,
   output logic              res_ack,
   output logic              err_ack,
   output logic              clk_1khz,
   output logic [DISP_W-1:0] data_out,
   output logic [1:0]        mode
);

   localparam int DIV    = scan_div(CLK_FREQ, SCAN_FREQ);
   localparam int HOLD_W = $clog2(HOLD_MS + 1);

   // Elaboration-time parameter sanity checks.
   if (DIV < 2 || (CLK_FREQ % (2 * SCAN_FREQ)) != 0) begin : g_bad_div
      $error("disp_ctrl: CLK_FREQ/(2*SCAN_FREQ) must be an integer >= 2");
   end
   if (HOLD_MS < 1 || BLINK_MS < 1) begin : g_bad_ms
      $error("disp_ctrl: HOLD_MS and BLINK_MS must be >= 1");
   end

   logic w_ms_tick;

   scan_clk_div #(
      .DIV (DIV)
   ) u_scan_clk_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_1khz (clk_1khz),
      .ms_tick  (w_ms_tick)
   );

   state_t            r_state,   w_state_next;
   disp_word_t        r_data,    w_data_next;
   logic              r_res_ack, w_res_ack_next;
   logic              r_err_ack, w_err_ack_next;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
   logic [HOLD_W-1:0] w_hold_inc;

   // Request arbitration: error beats clear beats result; results are
   // ignored while an error is displayed.
   logic w_take_err, w_take_clr, w_take_res;

   assign w_take_err = err_vld;
   assign w_take_clr = ~err_vld & clr;
   assign w_take_res = ~err_vld & ~clr & res_vld & (r_state != ST_ERROR);
   assign w_hold_inc = r_hold_cnt + 1'b1;

`ifdef DISP_ERR_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_MS + 1);

   disp_word_t         r_err_word,    w_err_word_next;
   logic [BLINK_W-1:0] r_blink_cnt,   w_blink_cnt_next;
   logic               r_blink_phase, w_blink_phase_next;
   logic [BLINK_W-1:0] w_blink_inc;

   assign w_blink_inc = r_blink_cnt + 1'b1;
`endif

   // Next-state, next-data and ack decode.
   always_comb begin
      w_state_next    = r_state;
      w_data_next     = r_data;
      w_res_ack_next  = 1'b0;
      w_err_ack_next  = 1'b0;
      w_hold_cnt_next = r_hold_cnt;
`ifdef DISP_ERR_BLINK_EN
      w_err_word_next    = r_err_word;
      w_blink_cnt_next   = r_blink_cnt;
      w_blink_phase_next = r_blink_phase;
`endif
      if (w_take_err) begin
         w_state_next   = ST_ERROR;
         w_data_next    = err_data;
         w_err_ack_next = 1'b1;
`ifdef DISP_ERR_BLINK_EN
         w_err_word_next    = err_data;
         w_blink_cnt_next   = '0;
         w_blink_phase_next = 1'b0;
`endif
      end else if (w_take_clr) begin
         w_state_next = ST_ENTRY;
         w_data_next  = entry_data;
      end else if (w_take_res) begin
         w_state_next    = ST_RESULT;
         w_data_next     = res_data;
         w_res_ack_next  = 1'b1;
         w_hold_cnt_next = '0;
      end else begin
         case (r_state)
            ST_ENTRY: begin
               w_data_next = entry_data;
            end
            ST_RESULT: begin
               if (w_ms_tick) begin
                  if (w_hold_inc == HOLD_W'(HOLD_MS)) begin
                     w_state_next    = ST_ENTRY;
                     w_data_next     = entry_data;
                     w_hold_cnt_next = '0;
                  end else begin
                     w_hold_cnt_next = w_hold_inc;
                  end
               end
            end
            ST_ERROR: begin
`ifdef DISP_ERR_BLINK_EN
               if (w_ms_tick) begin
                  if (w_blink_inc == BLINK_W'(BLINK_MS)) begin
                     w_blink_cnt_next   = '0;
                     w_blink_phase_next = ~r_blink_phase;
                     w_data_next        = r_blink_phase ? r_err_word : DISP_BLANK;
                  end else begin
                     w_blink_cnt_next   = w_blink_inc;
                  end
               end
`endif
            end
            default: begin
               w_state_next = ST_ENTRY;
               w_data_next  = entry_data;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ENTRY;
         r_data     <= DISP_BLANK;
         r_res_ack  <= 1'b0;
         r_err_ack  <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_data     <= w_data_next;
         r_res_ack  <= w_res_ack_next;
         r_err_ack  <= w_err_ack_next;
         r_hold_cnt <= w_hold_cnt_next;
      end
   end

`ifdef DISP_ERR_BLINK_EN
   // Blink registers: latched error word, half-period counter and phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_word    <= DISP_BLANK;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         r_err_word    <= w_err_word_next;
         r_blink_cnt   <= w_blink_cnt_next;
         r_blink_phase <= w_blink_phase_next;
      end
   end
`endif

   assign data_out = r_data;
   assign mode     = r_state;
   assign res_ack  = r_res_ack;
   assign err_ack  = r_err_ack;

endmodule

// File: tb/tb_disp_ctrl.sv
// tb_disp_ctrl: directed plus random stimulus for disp_ctrl, checked every
// cycle against a time-indexed behavioural model of the display scheduler.
// Honours DISP_ERR_BLINK_EN when the bundle is built with it defined.
module tb_disp_ctrl;
   import disp_pkg::*;

   localparam int CLK_FREQ  = 10_000;
   localparam int SCAN_FREQ = 1000;
   localparam int HOLD_MS   = 3;
   localparam int BLINK_MS  = 2;
   localparam int DIV       = CLK_FREQ / (2 * SCAN_FREQ);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] entry_data = '0;
   logic        res_vld = 1'b0;
   logic [23:0] res_data = '0;
   logic        err_vld = 1'b0;
   logic [23:0] err_data = '0;
   logic        clr = 1'b0;
   logic        res_ack, err_ack, clk_1khz;
   logic [23:0] data_out;
   logic [1:0]  mode;

   always #5 clk = ~clk;

   disp_ctrl #(
      .CLK_FREQ  (CLK_FREQ),
      .SCAN_FREQ (SCAN_FREQ),
      .HOLD_MS   (HOLD_MS),
      .BLINK_MS  (BLINK_MS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .entry_data (entry_data),
      .res_vld    (res_vld),
      .res_data   (res_data),
      .err_vld    (err_vld),
      .err_data   (err_data),
      .clr        (clr),
      .res_ack    (res_ack),
      .err_ack    (err_ack),
      .clk_1khz   (clk_1khz),
      .data_out   (data_out),
      .mode       (mode)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: time is the number of clock edges since reset release.
   int          m_e;
   int          m_ticks;
   logic [1:0]  m_mode;
   logic [23:0] m_res, m_err, m_data;
   logic        m_res_ack, m_err_ack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_e = 0; m_ticks = 0; m_mode = 2'd0;
      m_res = '0; m_err = '0; m_data = '0;
      m_res_ack = 1'b0; m_err_ack = 1'b0;
   endtask

   function automatic logic [23:0] error_view();
`ifdef DISP_ERR_BLINK_EN
      return ((m_ticks / BLINK_MS) % 2 == 1) ? 24'h000000 : m_err;
`else
      return m_err;
`endif
   endfunction

   // Apply one clock edge worth of spec rules to the model.
   task automatic model_step();
      bit tick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_e++;
      tick = (m_e % (2 * DIV)) == DIV;
      m_res_ack = 1'b0;
      m_err_ack = 1'b0;
      if (err_vld) begin
         m_mode = 2'd2; m_err = err_data; m_ticks = 0; m_err_ack = 1'b1;
      end else if (clr) begin
         m_mode = 2'd0;
      end else if (res_vld && m_mode != 2'd2) begin
         m_mode = 2'd1; m_res = res_data; m_ticks = 0; m_res_ack = 1'b1;
      end else if (tick && m_mode != 2'd0) begin
         m_ticks++;
         if (m_mode == 2'd1 && m_ticks == HOLD_MS) m_mode = 2'd0;
      end
      case (m_mode)
         2'd0:    m_data = entry_data;
         2'd1:    m_data = m_res;
         default: m_data = error_view();
      endcase
   endtask

   task automatic check_all();
      chk("clk_1khz", 32'(clk_1khz), 32'((m_e / DIV) % 2));
      chk("mode",     32'(mode),     32'(m_mode));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("res_ack",  32'(res_ack),  32'(m_res_ack));
      chk("err_ack",  32'(err_ack),  32'(m_err_ack));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      model_reset();
      #2;
      $display("step: reset asserted");
      check_all();
      chk("reset_data", 32'(data_out), 32'h0);
      run(2);

      $display("step: reset release, entry 000123");
      entry_data = 24'h000123;
      rst_n = 1'b1;
      cyc();
      chk("entry_lag", 32'(data_out), 32'h000123);
      run(11);
      entry_data = 24'h000456;
      cyc();
      chk("entry_track", 32'(data_out), 32'h000456);

      $display("step: result 000042 then hold expiry");
      res_vld = 1'b1; res_data = 24'h000042;
      cyc();
      res_vld = 1'b0;
      chk("res_mode", 32'(mode), 32'd1);
      chk("res_ack1", 32'(res_ack), 32'd1);
      chk("res_data", 32'(data_out), 32'h000042);
      run(35);
      chk("hold_back", 32'(mode), 32'd0);

      $display("step: result re-capture 000099 one ms later");
      res_vld = 1'b1; res_data = 24'h000042;
      cyc();
      res_vld = 1'b0;
      run(10);
      res_vld = 1'b1; res_data = 24'h000099;
      cyc();
      res_vld = 1'b0;
      chk("recap_data", 32'(data_out), 32'h000099);
      run(35);

      $display("step: err and res together, res in ERROR, clr");
      err_vld = 1'b1; err_data = 24'hE00000; res_vld = 1'b1; res_data = 24'h000077;
      cyc();
      err_vld = 1'b0; res_vld = 1'b0;
      chk("err_only_ack", 32'({err_ack, res_ack}), 32'b10);
      chk("err_data", 32'(data_out), 32'hE00000);
      run(3);
      res_vld = 1'b1; res_data = 24'h000055;
      cyc();
      res_vld = 1'b0;
      chk("err_ign_res", 32'(res_ack), 32'd0);
      run(45);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_mode", 32'(mode), 32'd0);
      run(4);

      $display("step: err and clr together from RESULT, reset mid-ERROR");
      res_vld = 1'b1; res_data = 24'h000011;
      cyc();
      res_vld = 1'b0;
      run(3);
      err_vld = 1'b1; err_data = 24'hE00001; clr = 1'b1;
      cyc();
      err_vld = 1'b0; clr = 1'b0;
      chk("errclr_mode", 32'(mode), 32'd2);
      run(6);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      run(2);
      rst_n = 1'b1;
      run(3);

      $display("step: random traffic");
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) entry_data = 24'($urandom);
         res_vld  = ($urandom_range(0, 99) < 8);
         res_data = 24'($urandom);
         err_vld  = ($urandom_range(0, 99) < 3);
         err_data = 24'($urandom);
         clr      = ($urandom_range(0, 99) < 4);
         if (res_vld || err_vld || clr)
            $display("txn %0d: res=%0b err=%0b clr=%0b res_data=%h err_data=%h",
                     i, res_vld, err_vld, clr, res_data, err_data);
         cyc();
         res_vld = 1'b0; err_vld = 1'b0; clr = 1'b0;
      end
      run(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
